count_sched: RTL
================

Name: count_sched

Overview:
- Round-robin scheduler that shares one start/stop 4-bit counter among N_REQ requesters.
- Each requester asks for a counted run of a given length. The block grants the counter to one requester at a time and sequences it: clear, start, wait for target, stop.
- It reports done or timeout-error back to the winning requester.
- Sits between the requester logic and the counter, and is the only driver of the counter's control inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CW, 4, counter width; must match the shared counter.
- TIMEOUT, 32, maximum RUN-state cycles before a run is aborted (>= 2^CW).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req  input  N_REQ  per-requester run request, level-held until done.
- len  input  N_REQ*CW  packed run lengths; requester i uses bits [i*CW +: CW].
- gnt  output  N_REQ  one-hot grant, held for the whole service.
- done  output  N_REQ  one-cycle completion pulse to the granted requester.
- err  output  N_REQ  one-cycle pulse coincident with done when the run timed out.
- busy  output  1  high in any state other than IDLE.
- cnt_clear  output  1  one-cycle clear to the shared counter.
- cnt_start  output  1  one-cycle start to the shared counter.
- cnt_stop  output  1  one-cycle stop to the shared counter.
- cnt_value  input  CW  current value of the shared counter.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge):
  - state=IDLE, rr_ptr=0, target=0, timer=0.
  - gnt, done, err, busy, cnt_clear, cnt_start, cnt_stop all 0.
  - Reset mid-run abandons the run with no done pulse; the counter is left as-is.
- States: IDLE, CLEAR, START, RUN, STOP, DONE.
- IDLE:
  - If any req bit is set, choose the first set bit searching upward from rr_ptr, wrapping modulo N_REQ.
  - Latch the winner index and its len into target.
  - Next cycle: CLEAR, with gnt one-hot for the winner.
  - rr_ptr <= (winner+1) mod N_REQ when the grant is issued.
- CLEAR: cnt_clear=1 for this cycle only.
  - If target==0, go directly to DONE: no start, no stop, done pulse, err=0.
  - Otherwise go to START.
- START: cnt_start=1 for one cycle; timer cleared; go to RUN.
- RUN:
  - timer increments each cycle.
  - If cnt_value==target, go to STOP; err_flag=0.
  - Else if timer==TIMEOUT-1, go to STOP; err_flag=1.
  - The value match has priority when both conditions occur in the same cycle.
- STOP: cnt_stop=1 for one cycle; go to DONE.
- DONE:
  - done[winner]=1, and err[winner]=err_flag, for one cycle.
  - gnt drops to 0 on the following cycle; state returns to IDLE.
- Latency, grant to done, for target>0 with a counter incrementing once per cycle after start: 4 + target cycles.
- Minimum gap between consecutive grants: one IDLE cycle.
- A req deasserted mid-service is ignored: the run completes and done still pulses.
- len changes after the grant are ignored because target is latched.
- A requester holding req after its done is re-granted only when the round-robin order reaches it again.
- At most one gnt, done, or err bit is set at any time.
- busy = (state != IDLE).
- cnt_value is compared at full CW width; there is no wrap logic in this block. Counter wrap is covered by TIMEOUT.

Test Plan:
- Single request: req=4'b0001, len0=5 → gnt=0001 next cycle; clear and start pulses once each; stop when cnt_value=5; done=0001, err=0; total 9 cycles grant→done.
- Contention: req=4'b1111, all len=2, rr_ptr=0 → grant order 0,1,2,3, then back to 0; never two gnt bits set.
- Zero length: req=4'b0100, len2=0 → CLEAR then DONE; cnt_start and cnt_stop never asserted; done=0100, err=0.
- Timeout: hold cnt_value=0, len=3 → after 32 RUN cycles, cnt_stop pulses; done and err both pulse on the granted bit.
- Match at timeout edge: cnt_value reaches target exactly when timer==TIMEOUT-1 → err=0.
- Reset mid-RUN: drive reset=0 for one edge → all outputs 0 next cycle; no done; rr_ptr=0; a new request is served normally afterward.

Source files
------------

// File: rtl/count_sched_if.sv
// Bundle between requesters, the scheduler and the shared 4-bit counter.
//
// Handshake: a requester raises req[i] with len[i] stable and holds req
// until it sees done[i]. gnt[i] marks ownership of the counter from the
// cycle after acceptance through the done cycle. done[i] is a single-cycle
// acknowledgment, and err[i] may pulse only in that same cycle. The
// cnt_clear/cnt_start/cnt_stop strobes are one-cycle commands with no
// back-pressure. cnt_value is sampled every cycle.
interface count_sched_if #(
  parameter int N_REQ = 4,
  parameter int CW    = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*CW-1:0] len;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic                busy;
  logic                cnt_clear;
  logic                cnt_start;
  logic                cnt_stop;
  logic [CW-1:0]       cnt_value;

  // Scheduler side
  modport master (
    input  req, len, cnt_value,
    output gnt, done, err, busy, cnt_clear, cnt_start, cnt_stop
  );

  // Requester and counter side
  modport slave (
    output req, len, cnt_value,
    input  gnt, done, err, busy, cnt_clear, cnt_start, cnt_stop
  );
endinterface

// File: rtl/count_sched.sv
// Round-robin scheduler that shares one start/stop counter among N_REQ
// requesters. It owns the counter's control strobes and sequences each run
// in this order: clear, start, wait for target or timeout, stop, done.
module count_sched #(
  parameter int N_REQ   = 4,
  parameter int CW      = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                clk,
  input  logic                reset,
  count_sched_if.master       sched_if,
  output logic [2:0]          state_dbg_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [CW-1:0]     target_q;
  logic [TW-1:0]     timer_q;
  logic              err_flag_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [N_REQ-1:0]  err_q;
  logic              busy_q;
  logic              clr_q;
  logic              start_q;
  logic              stop_q;

  logic              win_vld_d;
  logic [IW-1:0]     win_idx_d;
  logic [IW-1:0]     idx_v;
  logic [IW-1:0]     rr_ptr_d;
  logic [CW-1:0]     len_sel_d;
  logic [N_REQ-1:0]  gnt_d;

  // Pick the first requester at or above rr_ptr, wrapping; scanning downward
  // lets the lowest offset overwrite the others.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    idx_v     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx_v = IW'((int'(rr_ptr_q) + k) % N_REQ);
      if (sched_if.req[idx_v]) begin
        win_vld_d = 1'b1;
        win_idx_d = idx_v;
      end
    end
  end

  // Extract the winner's run length from the packed len bus.
  always_comb begin
    len_sel_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_d == IW'(i)) len_sel_d = sched_if.len[i*CW +: CW];
    end
  end

  assign rr_ptr_d = (int'(win_idx_d) == N_REQ - 1) ? '0 : win_idx_d + IW'(1);
  assign gnt_d    = N_REQ'(1) << win_idx_d;

  // Sequencing FSM; every output is a register updated on entry to a state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      target_q   <= '0;
      timer_q    <= '0;
      err_flag_q <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      done_q  <= '0;
      err_q   <= '0;
      clr_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            state_q  <= S_CLEAR;
            gnt_q    <= gnt_d;
            target_q <= len_sel_d;
            rr_ptr_q <= rr_ptr_d;
            clr_q    <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_CLEAR: begin
          // A zero-length run never touches start/stop.
          if (target_q == '0) begin
            state_q    <= S_DONE;
            err_flag_q <= 1'b0;
            done_q     <= gnt_q;
          end else begin
            state_q <= S_START;
            start_q <= 1'b1;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // Value match wins over timeout when both land on the same cycle.
          if (sched_if.cnt_value == target_q) begin
            state_q    <= S_STOP;
            stop_q     <= 1'b1;
            err_flag_q <= 1'b0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q    <= S_STOP;
            stop_q     <= 1'b1;
            err_flag_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_STOP: begin
          state_q <= S_DONE;
          done_q  <= gnt_q;
          err_q   <= err_flag_q ? gnt_q : '0;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sched_if.gnt       = gnt_q;
  assign sched_if.done      = done_q;
  assign sched_if.err       = err_q;
  assign sched_if.busy      = busy_q;
  assign sched_if.cnt_clear = clr_q;
  assign sched_if.cnt_start = start_q;
  assign sched_if.cnt_stop  = stop_q;
  assign state_dbg_o        = state_q;

endmodule
